// File: rtl/ddr_fifo_pkg.sv
// Shared constants and occupancy-to-flag helpers for the DDR synchronous FIFO.
package ddr_fifo_pkg;

  localparam string FIFO_TRUE  = "TRUE";
  localparam string FIFO_FALSE = "FALSE";

  function automatic logic flag_full(input int cnt, input int depth);
    return (cnt == depth);
  endfunction

  function automatic logic flag_empty(input int cnt);
    return (cnt == 0);
  endfunction

  function automatic logic flag_afull(input int cnt, input int thresh);
    return (cnt >= thresh);
  endfunction

  function automatic logic flag_aempty(input int cnt, input int thresh);
    return (cnt <= thresh);
  endfunction

endpackage

// File: rtl/ddr_sync_fifo_if.sv
// Push/pop handshake and status bundle between the FIFO and its user.
interface ddr_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wdata, rd_en,
    input  rdata, rvalid, full, almost_full, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wdata, rd_en,
    output rdata, rvalid, full, almost_full, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/ddr_sdp_ram_core.sv
// Simple dual-port block RAM: re issues a read, data+valid appear 1 cycle later (2 with OREG).
// No backpressure; cancel kills any read still in the pipe and leaves rdata untouched.
module ddr_sdp_ram_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter bit OREG       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cancel,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_vld;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-first: a same-edge write to raddr returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_q   <= '0;
      ram_vld <= 1'b0;
    end else begin
      ram_vld <= re && !cancel;
      if (re && !cancel) ram_q <= mem[raddr];
    end
  end

  if (OREG) begin : g_oreg
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_vld;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q   <= '0;
        out_vld <= 1'b0;
      end else begin
        out_vld <= ram_vld && !cancel;
        if (ram_vld && !cancel) out_q <= ram_q;
      end
    end

    assign rdata  = out_q;
    assign rvalid = out_vld;
  end else begin : g_noreg
    assign rdata  = ram_q;
    assign rvalid = ram_vld;
  end

endmodule

// File: rtl/ddr_sync_fifo.sv
// Single-clock FIFO with registered flags; rvalid follows an accepted pop by 2 edges (3 with OUTPUT_REG).
// Never stalls the user: pushes when full / pops when empty are dropped and latched as sticky errors.
module ddr_sync_fifo
  import ddr_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH    = 8,
  parameter int    ADDR_WIDTH    = 9,
  parameter string OUTPUT_REG    = "TRUE",
  parameter int    AFULL_THRESH  = 2**ADDR_WIDTH-4,
  parameter int    AEMPTY_THRESH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  ddr_sync_fifo_if.slave fif
);

  localparam int DEPTH    = 2**ADDR_WIDTH;
  localparam bit USE_OREG = (OUTPUT_REG == FIFO_TRUE);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_addr_q;
  logic [ADDR_WIDTH:0]   count_q, cnt_nxt;
  logic                  full_q, afull_q, empty_q, aempty_q;
  logic                  ovf_q, udf_q, pop_q;
  logic                  push_ok, pop_ok;

  assign push_ok = fif.wr_en && !full_q;
  assign pop_ok  = fif.rd_en && !empty_q;

  always_comb begin
    cnt_nxt = count_q;
    if (fif.flush)              cnt_nxt = '0;
    else if (push_ok && !pop_ok) cnt_nxt = count_q + CNT_ONE;
    else if (pop_ok && !push_ok) cnt_nxt = count_q - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_addr_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      pop_q     <= 1'b0;
    end else begin
      count_q   <= cnt_nxt;
      full_q    <= flag_full(int'(cnt_nxt), DEPTH);
      afull_q   <= flag_afull(int'(cnt_nxt), AFULL_THRESH);
      empty_q   <= flag_empty(int'(cnt_nxt));
      aempty_q  <= flag_aempty(int'(cnt_nxt), AEMPTY_THRESH);
      pop_q     <= pop_ok && !fif.flush;
      rd_addr_q <= rd_ptr;
      if (fif.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_q  <= 1'b0;
        udf_q  <= 1'b0;
      end else begin
        if (push_ok)                 wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)                  rd_ptr <= rd_ptr + PTR_ONE;
        if (fif.wr_en && full_q)     ovf_q  <= 1'b1;
        if (fif.rd_en && empty_q)    udf_q  <= 1'b1;
      end
    end
  end

  // Read is issued one edge after the pop so the RAM address comes from a register.
  ddr_sdp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .OREG       (USE_OREG)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .cancel (fif.flush),
    .we     (push_ok && !fif.flush),
    .waddr  (wr_ptr),
    .wdata  (fif.wdata),
    .re     (pop_q),
    .raddr  (rd_addr_q),
    .rdata  (fif.rdata),
    .rvalid (fif.rvalid)
  );

  assign fif.count        = count_q;
  assign fif.full         = full_q;
  assign fif.almost_full  = afull_q;
  assign fif.empty        = empty_q;
  assign fif.almost_empty = aempty_q;
  assign fif.overflow     = ovf_q;
  assign fif.underflow    = udf_q;

endmodule

// File: tb/tb_ddr_sync_fifo.sv
// Directed scoreboard bench: dut0 has the output register, dut1 does not.
module tb_ddr_sync_fifo;
  import ddr_fifo_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ddr_sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) f0 ();
  ddr_sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) f1 ();

  ddr_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .OUTPUT_REG(FIFO_TRUE), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut0 (.clk(clk), .rst_n(rst_n), .fif(f0.slave));

  ddr_sync_fifo #(
    .DATA_WIDTH(8), .ADDR_WIDTH(2), .OUTPUT_REG(FIFO_FALSE), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .fif(f1.slave));

  typedef struct {
    logic [7:0] d;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic score(input string nm, input bit have, input exp_t e, input logic [7:0] d);
    n_chk++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s: unexpected rvalid with rdata=%02h at cycle %0d", nm, d, cyc);
    end else if (d !== e.d || cyc != e.cyc) begin
      n_fail++;
      $display("FAIL %s: rdata=%02h at cycle %0d, expected %02h at cycle %0d", nm, d, cyc, e.d, e.cyc);
    end
  endtask

  // Monitor: every rvalid strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (f0.rvalid) begin
      e    = '{d: 8'h00, cyc: 0};
      have = (q0.size() > 0);
      if (have) e = q0.pop_front();
      score("rd_dut0", have, e, f0.rdata);
    end
    if (f1.rvalid) begin
      e    = '{d: 8'h00, cyc: 0};
      have = (q1.size() > 0);
      if (have) e = q1.pop_front();
      score("rd_dut1", have, e, f1.rdata);
    end
  end

  // One cycle of stimulus; a pop's data is due 3 edges later on dut0, 2 on dut1.
  task automatic step(input bit which, input bit w, input logic [7:0] wd, input bit r,
                      input bit ex, input logic [7:0] ed);
    if (!which) begin
      f0.wr_en = w; f0.wdata = wd; f0.rd_en = r;
      if (ex) q0.push_back('{d: ed, cyc: cyc + 3});
    end else begin
      f1.wr_en = w; f1.wdata = wd; f1.rd_en = r;
      if (ex) q1.push_back('{d: ed, cyc: cyc + 2});
    end
    @(negedge clk);
    f0.wr_en = 1'b0; f0.rd_en = 1'b0;
    f1.wr_en = 1'b0; f1.rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, int'(f0.count), 0);
    chk({tag, "_empty"}, int'(f0.empty), 1);
    chk({tag, "_aempty"}, int'(f0.almost_empty), 1);
    chk({tag, "_full"}, int'(f0.full), 0);
    chk({tag, "_afull"}, int'(f0.almost_full), 0);
    chk({tag, "_ovf"}, int'(f0.overflow), 0);
    chk({tag, "_udf"}, int'(f0.underflow), 0);
    chk({tag, "_rvalid"}, int'(f0.rvalid), 0);
    chk({tag, "_rdata"}, int'(f0.rdata), 0);
  endtask

  logic [7:0] fill [4];

  initial begin
    f0.flush = 1'b0; f0.wr_en = 1'b0; f0.wdata = '0; f0.rd_en = 1'b0;
    f1.flush = 1'b0; f1.wr_en = 1'b0; f1.wdata = '0; f1.rd_en = 1'b0;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");

    // No output register: push 0x77 on the first edge out of reset, pop next edge.
    rst_n = 1'b1;
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    chk("oreg_false_count_push", int'(f1.count), 1);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    chk("oreg_false_count_pop", int'(f1.count), 0);
    idle(3);

    // Fill to full.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, fill[i], 1'b0, 1'b0, 8'h00);
      chk($sformatf("fill%0d_count", i), int'(f0.count), i + 1);
      chk($sformatf("fill%0d_afull", i), int'(f0.almost_full), (i >= 2) ? 1 : 0);
      chk($sformatf("fill%0d_full", i), int'(f0.full), (i == 3) ? 1 : 0);
      chk($sformatf("fill%0d_aempty", i), int'(f0.almost_empty), (i == 0) ? 1 : 0);
    end

    // Push into a full FIFO is dropped.
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00);
    chk("full_push_ovf", int'(f0.overflow), 1);
    chk("full_push_count", int'(f0.count), 4);

    // Full with push and pop together: only the pop goes through.
    step(1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 8'h11);
    chk("full_both_count", int'(f0.count), 3);
    chk("full_both_full", int'(f0.full), 0);
    chk("full_both_ovf", int'(f0.overflow), 1);

    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44);
    chk("drain_count", int'(f0.count), 0);
    chk("drain_empty", int'(f0.empty), 1);
    idle(3);

    // Pop from empty: underflow, no strobe.
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("empty_pop_udf", int'(f0.underflow), 1);
    chk("empty_pop_count", int'(f0.count), 0);
    idle(4);

    // Flush with a pop in flight and a competing push: everything cleared, no strobe.
    step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    f0.flush = 1'b1;
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
    f0.flush = 1'b0;
    chk("flush_count", int'(f0.count), 0);
    chk("flush_empty", int'(f0.empty), 1);
    chk("flush_ovf", int'(f0.overflow), 0);
    chk("flush_udf", int'(f0.underflow), 0);
    idle(4);

    // Steady push+pop at occupancy 1, wrapping both pointers.
    step(1'b0, 1'b1, 8'h9F, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'hA0 + 8'(i), 1'b1, 1'b1, (i == 0) ? 8'h9F : 8'hA0 + 8'(i - 1));
      chk($sformatf("stream%0d_count", i), int'(f0.count), 1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA9);
    chk("stream_end_count", int'(f0.count), 0);
    idle(4);

    // Reset mid-burst with a pop in flight.
    step(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hB3, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    q0.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00);
    chk("post_reset_count", int'(f0.count), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC3);
    idle(5);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_sync_fifo.md
DDR_SYNC_FIFO -- requirements
Module: ddr_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: storage depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter OUTPUT_REG, default "TRUE": adds one read-data output register stage.
REQ-004 SHALL have parameter AFULL_THRESH, default 2**ADDR_WIDTH-4: almost_full level.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 4: almost_empty level.
REQ-006 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port flush  input  1  synchronous clear of contents and error flags.
REQ-009 SHALL have port wr_en  input  1  push request.
REQ-010 SHALL have port wdata  input  DATA_WIDTH  push data.
REQ-011 SHALL have port rd_en  input  1  pop request.
REQ-012 SHALL have port rdata  output  DATA_WIDTH  popped data.
REQ-013 SHALL have port rvalid  output  1  one-cycle strobe marking rdata valid.
REQ-014 SHALL have port full, almost_full, empty, almost_empty  output  1 each  status flags.
REQ-015 SHALL have port count  output  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
REQ-016 SHALL have port overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Push SHALL be accepted iff wr_en=1 and full=0; pop SHALL be accepted iff rd_en=1 and empty=0.
REQ-018 Rejected push SHALL set overflow; rejected pop SHALL set underflow; both stay set until flush or reset.
REQ-019 Flags SHALL be registered and derived from count: full=(count==2**ADDR_WIDTH), empty=(count==0), almost_full=(count>=AFULL_THRESH), almost_empty=(count<=AEMPTY_THRESH).
REQ-020 Count SHALL update the cycle after an edge: +1 push only, -1 pop only, unchanged for simultaneous accepted push and pop.
REQ-021 When full, simultaneous wr_en and rd_en SHALL accept the pop only, reject the push and set overflow; when empty, both asserted SHALL accept the push only and set underflow.
REQ-022 Write and read pointers SHALL be ADDR_WIDTH bits and wrap from 2**ADDR_WIDTH-1 to 0 without gaps.
REQ-023 Pop accepted at edge T SHALL present data with rvalid=1 after edge T+1 (OUTPUT_REG="FALSE") or T+2 (OUTPUT_REG="TRUE").
REQ-024 Word pushed at edge T SHALL be poppable at edge T+1 with the written value (no stale read).
REQ-025 rdata SHALL hold its last value when rvalid=0.
REQ-026 Data order SHALL be strictly first-in first-out.
REQ-027 flush SHALL take priority over wr_en/rd_en in the same cycle: pointers, count, overflow, underflow cleared, in-flight rvalid strobes cancelled, rdata held.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rvalid=0, rdata=0.
REQ-029 Reset mid-operation SHALL discard all stored words and pending reads; storage array contents need not be cleared.
REQ-030 First push SHALL be accepted on the first rising edge with rst_n=1.

Structure
REQ-031 Shared package ddr_fifo_pkg SHALL hold the occupancy/flag helper functions and the "TRUE"/"FALSE" parameter string constants.
REQ-032 Storage SHALL be one sub-module ddr_sdp_ram_core (write port, registered read port, optional output register), with no reset on the array.
REQ-033 Storage SHALL map to block RAM; the pointer, count and flag logic SHALL live in ddr_sync_fifo.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, AFULL_THRESH=3, AEMPTY_THRESH=1, OUTPUT_REG="TRUE" unless stated)
REQ-034 Push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full at count 3; full at count 4; pop x4 -> rdata 0x11..0x44 each 2 cycles after its pop with rvalid pulse.
REQ-035 Full, push 0x55 -> overflow=1, count 4, contents unchanged; empty, pop -> underflow=1, rvalid stays 0.
REQ-036 Full, wr_en and rd_en with 0x66 -> pop accepted (0x11 out), push rejected, count 3, overflow=1.
REQ-037 Ten push/pop cycles 0xA0..0xA9 at count 1 -> pointers wrap; outputs in order; count remains 1.
REQ-038 Push 0x77 at T and pop at T+1, OUTPUT_REG="FALSE" -> rdata=0x77 with rvalid at T+2.
REQ-039 rst_n low mid-burst with a pop in flight -> all outputs at REQ-028 values immediately; no rvalid after release.
